// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: two-port round-robin arbiter/sequencer for a single-port
// synchronous memory with a shared tri-state data bus.
// Each transaction runs IDLE (grant) -> ACCESS (memory cycle) -> DONE (ack).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   reqN_i/weN_i/addrN_i/wdataN_i   client N request, write flag, address, write data
//   ackN_o                  one-cycle completion pulse for client N
//   rdataN_o                last read result for client N
//   busy_o                  arbiter is not idle
//   mem_wr_o/mem_rd_o/mem_addr_o    memory control
//   mem_data_io             shared data bus; driven here only during a write ACCESS
module mem_arbiter #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [AWIDTH-1:0] addr0_i,
  input  logic [AWIDTH-1:0] addr1_i,
  input  logic [DWIDTH-1:0] wdata0_i,
  input  logic [DWIDTH-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DWIDTH-1:0] rdata0_o,
  output logic [DWIDTH-1:0] rdata1_o,
  output logic              busy_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  inout  wire  [DWIDTH-1:0] mem_data_io
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e              state_q;
  logic                sel_q;
  logic                last_q;
  logic                drive_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                mem_wr_q;
  logic                mem_rd_q;
  logic [AWIDTH-1:0]   mem_addr_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [DWIDTH-1:0]   rdata0_q;
  logic [DWIDTH-1:0]   rdata1_q;
  logic                busy_q;

  logic                win1_c;
  logic                win_we_c;
  logic [AWIDTH-1:0]   win_addr_c;
  logic [DWIDTH-1:0]   win_wdata_c;

  // Round-robin pick: port 1 wins when alone, or on a tie when port 0 went last.
  always_comb begin
    win1_c      = req1_i & (~req0_i | ~last_q);
    win_we_c    = we0_i;
    win_addr_c  = addr0_i;
    win_wdata_c = wdata0_i;
    if (win1_c) begin
      win_we_c    = we1_i;
      win_addr_c  = addr1_i;
      win_wdata_c = wdata1_i;
    end
  end

  // Sequencer; memory controls are set up on the grant edge so they are
  // registered for the whole ACCESS cycle and cleared on the edge ending it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_i | req1_i) begin
            state_q    <= ST_ACCESS;
            busy_q     <= 1'b1;
            sel_q      <= win1_c;
            last_q     <= win1_c;
            mem_addr_q <= win_addr_c;
            wdata_q    <= win_wdata_c;
            mem_wr_q   <= win_we_c;
            mem_rd_q   <= ~win_we_c;
            drive_q    <= win_we_c;
          end
        end
        ST_ACCESS: begin
          state_q  <= ST_DONE;
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
          drive_q  <= 1'b0;
          // Memory read data is valid on the bus while rd is high.
          if (mem_rd_q) begin
            if (sel_q) rdata1_q <= mem_data_io;
            else       rdata0_q <= mem_data_io;
          end
          ack0_q <= ~sel_q;
          ack1_q <= sel_q;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
          drive_q  <= 1'b0;
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data_io = drive_q ? wdata_q : {DWIDTH{1'bz}};

  assign ack0_o     = ack0_q;
  assign ack1_o     = ack1_q;
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;
  assign busy_o     = busy_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: behavioural memory on the shared bus, per-port
// driver tasks pushing expected acks into per-port queues, and a monitor
// that pops and compares on every ack plus per-cycle bus checks.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       busy, mem_wr, mem_rd;
  logic [4:0] mem_addr;
  wire  [7:0] mem_data;

  mem_arbiter #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_i     (req0),
    .req1_i     (req1),
    .we0_i      (we0),
    .we1_i      (we1),
    .addr0_i    (addr0),
    .addr1_i    (addr1),
    .wdata0_i   (wdata0),
    .wdata1_i   (wdata1),
    .ack0_o     (ack0),
    .ack1_o     (ack1),
    .rdata0_o   (rdata0),
    .rdata1_o   (rdata1),
    .busy_o     (busy),
    .mem_wr_o   (mem_wr),
    .mem_rd_o   (mem_rd),
    .mem_addr_o (mem_addr),
    .mem_data_io(mem_data)
  );

  // Memory device: write on clock edge, combinational read onto the bus.
  logic [7:0] mem [32] = '{default: 8'h00};
  assign mem_data = mem_rd ? mem[mem_addr] : 8'bz;
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data;

  // Reference contents as seen by the clients.
  logic [7:0] ref_mem [32] = '{default: 8'h00};

  typedef struct {
    int         exp_cyc;
    logic       is_rd;
    logic [7:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one transaction on port p, starting just after a rising edge.
  // lat < 0 skips the ack-timing check. Returns just after the edge that
  // ends the ack cycle; keep=1 leaves req high for a follow-on transaction.
  task automatic txn(input int p, input logic we, input logic [4:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd, input int lat, input bit keep);
    exp_t e;
    bit   got;
    e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
    e.is_rd   = ~we;
    e.data    = exp_rd;
    if (p == 0) begin
      q0.push_back(e);
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      q1.push_back(e);
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    if (!got) check($sformatf("ack%0d_timeout", p), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack0"},   32'(ack0),     32'd0);
    check({tag, "_ack1"},   32'(ack1),     32'd0);
    check({tag, "_rdata0"}, 32'(rdata0),   32'd0);
    check({tag, "_rdata1"}, 32'(rdata1),   32'd0);
    check({tag, "_mem_wr"}, 32'(mem_wr),   32'd0);
    check({tag, "_mem_rd"}, 32'(mem_rd),   32'd0);
    check({tag, "_addr"},   32'(mem_addr), 32'd0);
    check({tag, "_busy"},   32'(busy),     32'd0);
  endtask

  // Monitor: scoreboard pops on acks, plus bus-safety checks every cycle.
  initial begin
    exp_t e;
    int   wr_run;
    logic bus_x;
    wr_run = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ack_both", 32'(ack0 & ack1), 32'd0);
        check("wr_rd_both", 32'(mem_wr & mem_rd), 32'd0);
        bus_x = 1'b0;
        for (int i = 0; i < 8; i++) if (mem_data[i] === 1'bx) bus_x = 1'b1;
        check("bus_x", 32'(bus_x), 32'd0);
        if (mem_wr) wr_run++;
        else begin
          if (wr_run != 0) check("mem_wr_width", 32'(wr_run), 32'd1);
          wr_run = 0;
        end
        if (ack0) begin
          if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL ack0_unexpected: got ack0=1 expected no ack (cycle %0d)", cyc);
          end else begin
            e = q0.pop_front();
            if (e.exp_cyc >= 0) check("ack0_cycle", 32'(cyc), 32'(e.exp_cyc));
            if (e.is_rd) check("rdata0", 32'(rdata0), 32'(e.data));
          end
        end
        if (ack1) begin
          if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL ack1_unexpected: got ack1=1 expected no ack (cycle %0d)", cyc);
          end else begin
            e = q1.pop_front();
            if (e.exp_cyc >= 0) check("ack1_cycle", 32'(cyc), 32'(e.exp_cyc));
            if (e.is_rd) check("rdata1", 32'(rdata1), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    logic [4:0] a0, a1;
    logic [7:0] d0, d1, e0, e1;
    logic       w0, w1;
    int         p;

    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rst_n = 1'b0;
    #2;
    check_reset_values("por");
    do_reset();

    // Simultaneous first requests: port 0 wins the first tie.
    fork
      txn(0, 1'b1, 5'd3, 8'h11, 8'h00, 2, 1'b0);
      txn(1, 1'b1, 5'd4, 8'h22, 8'h00, 5, 1'b0);
    join
    ref_mem[3] = 8'h11; ref_mem[4] = 8'h22;
    txn(0, 1'b0, 5'd3, 8'h00, 8'h11, 2, 1'b0);
    txn(1, 1'b0, 5'd4, 8'h00, 8'h22, 2, 1'b0);

    // Single write then read on port 0.
    txn(0, 1'b1, 5'd5, 8'hA5, 8'h00, 2, 1'b0);
    ref_mem[5] = 8'hA5;
    txn(0, 1'b0, 5'd5, 8'h00, 8'hA5, 2, 1'b0);

    // Continuous contention: acks alternate 0,1,0,1 every 3 cycles.
    do_reset();
    fork
      begin
        txn(0, 1'b0, 5'd3, 8'h00, 8'h11, 2, 1'b1);
        txn(0, 1'b0, 5'd3, 8'h00, 8'h11, 5, 1'b0);
      end
      begin
        txn(1, 1'b0, 5'd4, 8'h00, 8'h22, 5, 1'b1);
        txn(1, 1'b0, 5'd4, 8'h00, 8'h22, 5, 1'b0);
      end
    join

    // Back-to-back on port 1 with req held across the ack.
    do_reset();
    txn(1, 1'b1, 5'd9, 8'h5A, 8'h00, 2, 1'b1);
    ref_mem[9] = 8'h5A;
    txn(1, 1'b0, 5'd9, 8'h00, 8'h5A, 2, 1'b0);

    // Async reset in the middle of a write ACCESS cycle.
    do_reset();
    txn(0, 1'b1, 5'd7, 8'h3C, 8'h00, 2, 1'b0);
    ref_mem[7] = 8'h3C;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'hFF;
    @(posedge clk);
    #3;
    check("abort_in_access_wr", 32'(mem_wr), 32'd1);
    check("abort_in_access_bus", 32'(mem_data), 32'hFF);
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("async_held_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    txn(0, 1'b0, 5'd7, 8'h00, 8'h3C, 2, 1'b0);

    // Random mix of 200 transactions against the reference model.
    for (int k = 0; k < 100; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        a0 = 5'($urandom_range(0, 31));
        a1 = a0 ^ 5'($urandom_range(1, 31));
        w0 = 1'($urandom_range(0, 1));
        w1 = 1'($urandom_range(0, 1));
        d0 = 8'($urandom_range(0, 255));
        d1 = 8'($urandom_range(0, 255));
        e0 = ref_mem[a0];
        e1 = ref_mem[a1];
        fork
          txn(0, w0, a0, d0, e0, -1, 1'b0);
          txn(1, w1, a1, d1, e1, -1, 1'b0);
        join
        if (w0) ref_mem[a0] = d0;
        if (w1) ref_mem[a1] = d1;
      end else begin
        for (int j = 0; j < 2; j++) begin
          p  = int'($urandom_range(0, 1));
          a0 = 5'($urandom_range(0, 31));
          w0 = 1'($urandom_range(0, 1));
          d0 = 8'($urandom_range(0, 255));
          e0 = ref_mem[a0];
          txn(p, w0, a0, d0, e0, 2, 1'b0);
          if (w0) ref_mem[a0] = d0;
        end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
